// File: rtl/coalescing_writebuffer.sv
// Write buffer between CPU and memory: circular FIFO of {adr, data, byteen} entries.
// Repeat writes to the youngest entry are merged; the buffer can be snooped by address.
module coalescing_writebuffer #(
    parameter int ADRW     = 30,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADRW-1:0]   adr,
    input  logic [DW-1:0]     data,
    input  logic [DW/8-1:0]   byteen,
    input  logic              en,
    output logic              done,
    input  logic [ADRW-1:0]   radr,
    output logic              rhit,
    output logic [DW-1:0]     rdata,
    output logic [DW/8-1:0]   rbyteen,
    output logic [ADRW-1:0]   memadr,
    output logic [DW-1:0]     memdata,
    output logic [DW/8-1:0]   membyteen,
    output logic              memen,
    input  logic              memdone,
    output logic              full,
    output logic              empty
);
    localparam int BW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADRW-1:0] adr_mem  [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];
    logic [BW-1:0]   be_mem   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] young;
    logic [PW-1:0] idx;
    logic [CW-1:0] count;
    logic          hit;
    logic          push;
    logic          pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign memen     = !empty;
    assign memadr    = adr_mem[head];
    assign memdata   = data_mem[head];
    assign membyteen = be_mem[head];

    // The youngest entry may only absorb a write if it is not the one memory is taking.
    assign young = tail - PW'(1);
    assign hit   = (COALESCE != 0) && en && !empty && (adr == adr_mem[young])
                   && !((young == head) && memen);
    assign done  = reset && en && (!full || hit);
    assign push  = done && !hit && (byteen != '0);
    assign pop   = memen && memdone;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[tail]  <= adr;
            data_mem[tail] <= data;
            be_mem[tail]   <= byteen;
        end else if (done && hit) begin
            for (int b = 0; b < BW; b++) begin
                if (byteen[b]) data_mem[young][8*b +: 8] <= data[8*b +: 8];
            end
            be_mem[young] <= be_mem[young] | byteen;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        rhit    = 1'b0;
        rdata   = '0;
        rbyteen = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (adr_mem[idx] == radr)) begin
                rhit    = 1'b1;
                rdata   = data_mem[idx];
                rbyteen = be_mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_coalescing_writebuffer.sv
// Bench for coalescing_writebuffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the buffer's behaviour.
module tb_coalescing_writebuffer;
    localparam int ADRW  = 30;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [ADRW-1:0] adr = '0;
    logic [DW-1:0]   data = '0;
    logic [BW-1:0]   byteen = '0;
    logic            en = 1'b0;
    logic            done;
    logic [ADRW-1:0] radr = '0;
    logic            rhit;
    logic [DW-1:0]   rdata;
    logic [BW-1:0]   rbyteen;
    logic [ADRW-1:0] memadr;
    logic [DW-1:0]   memdata;
    logic [BW-1:0]   membyteen;
    logic            memen;
    logic            memdone = 1'b0;
    logic            full;
    logic            empty;

    always #5 clk = ~clk;

    coalescing_writebuffer #(.ADRW(ADRW), .DW(DW), .DEPTH(DEPTH), .COALESCE(1)) dut (
        .clk(clk), .reset(reset), .adr(adr), .data(data), .byteen(byteen), .en(en),
        .done(done), .radr(radr), .rhit(rhit), .rdata(rdata), .rbyteen(rbyteen),
        .memadr(memadr), .memdata(memdata), .membyteen(membyteen), .memen(memen),
        .memdone(memdone), .full(full), .empty(empty)
    );

    typedef struct {
        logic [ADRW-1:0] adr;
        logic [DW-1:0]   data;
        logic [BW-1:0]   be;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          last_done;
    logic          last_rhit;
    logic [DW-1:0] last_rdata;
    logic [BW-1:0] last_rbyteen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare combinational/registered outputs with the model, then advance the model.
    task automatic step(input logic r, input logic e, input logic [ADRW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b,
                        input logic md, input logic [ADRW-1:0] ra);
        int            sz;
        logic          hitm;
        logic          donem;
        logic          rhm;
        logic [DW-1:0] rdm;
        logic [BW-1:0] rbm;
        ent_t          t;
        @(negedge clk);
        reset = r; en = e; adr = a; data = d; byteen = b; memdone = md; radr = ra;
        #1;
        sz    = q.size();
        hitm  = r && e && (sz >= 2) && (q[sz-1].adr == a);
        donem = r && e && ((sz < DEPTH) || hitm);
        rhm = 1'b0; rdm = '0; rbm = '0;
        foreach (q[i]) begin
            if (q[i].adr == ra) begin
                rhm = 1'b1; rdm = q[i].data; rbm = q[i].be;
            end
        end
        last_done = done; last_rhit = rhit; last_rdata = rdata; last_rbyteen = rbyteen;
        check_val("done",  64'(done),  64'(donem));
        check_val("memen", 64'(memen), 64'(sz > 0));
        check_val("empty", 64'(empty), 64'(sz == 0));
        check_val("full",  64'(full),  64'(sz == DEPTH));
        check_val("rhit",  64'(rhit),  64'(rhm));
        check_val("rdata", 64'(rdata), 64'(rdm));
        check_val("rbyteen", 64'(rbyteen), 64'(rbm));
        if (sz > 0) begin
            check_val("memadr",    64'(memadr),    64'(q[0].adr));
            check_val("memdata",   64'(memdata),   64'(q[0].data));
            check_val("membyteen", 64'(membyteen), 64'(q[0].be));
        end
        @(posedge clk);
        if (!r) begin
            q.delete();
        end else begin
            if (donem && hitm) begin
                t = q[sz-1];
                for (int k = 0; k < BW; k++) if (b[k]) t.data[8*k +: 8] = d[8*k +: 8];
                t.be = t.be | b;
                q[sz-1] = t;
            end
            if (md && sz > 0) void'(q.pop_front());
            if (donem && !hitm && b != '0) begin
                t.adr = a; t.data = d; t.be = b;
                q.push_back(t);
            end
        end
    endtask

    task automatic wr(input logic [ADRW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] b, input logic md);
        step(1'b1, 1'b1, a, d, b, md, '0);
    endtask

    task automatic idle(input logic md, input logic [ADRW-1:0] ra);
        step(1'b1, 1'b0, '0, '0, '0, md, ra);
    endtask

    initial begin
        // Reset with a pending request: done must stay low.
        step(1'b0, 1'b1, 30'h3, 32'h1234, 4'hF, 1'b0, 30'h3);
        check_val("rst_done", 64'(last_done), 64'd0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        #2;
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_memen", 64'(memen), 64'd0);
        check_val("rst_full",  64'(full),  64'd0);

        // Single write into an empty buffer, seen on memory one cycle later.
        wr(30'h0, 32'hDEADBEEF, 4'hF, 1'b0);
        check_val("w1_done", 64'(last_done), 64'd1);
        #2;
        check_val("w1_memen",  64'(memen),     64'd1);
        check_val("w1_memadr", 64'(memadr),    64'd0);
        check_val("w1_memdat", 64'(memdata),   64'hDEADBEEF);
        check_val("w1_membe",  64'(membyteen), 64'hF);
        idle(1'b1, '0);

        // Fill to full, fifth write refused, drain in order.
        for (int k = 1; k <= 4; k++) begin
            wr(ADRW'(k), DW'(32'h100 + k), 4'hF, 1'b0);
            check_val("fill_done", 64'(last_done), 64'd1);
        end
        #2;
        check_val("fill_full", 64'(full), 64'd1);
        wr(30'h5, 32'h105, 4'hF, 1'b0);
        check_val("fill_refuse", 64'(last_done), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            #2;
            check_val("drain_order", 64'(memadr), 64'(k));
            idle(1'b1, '0);
        end
        #2;
        check_val("drain_empty", 64'(empty), 64'd1);

        // Coalesce into the youngest entry behind a different head.
        wr(30'h6, 32'h66666666, 4'hF, 1'b0);
        wr(30'h7, 32'hAABBCCDD, 4'hF, 1'b0);
        wr(30'h7, 32'h11223344, 4'h5, 1'b0);
        #2;
        check_val("coal_count", 64'(dut.count), 64'd2);
        idle(1'b1, '0);
        #2;
        check_val("coal_adr",  64'(memadr),    64'h7);
        check_val("coal_data", 64'(memdata),   64'hAA22CC44);
        check_val("coal_be",   64'(membyteen), 64'hF);
        idle(1'b1, '0);

        // Head in flight: no merge, snoop returns the youngest match.
        wr(30'h9, 32'h11111111, 4'h3, 1'b0);
        wr(30'h9, 32'h22222222, 4'hC, 1'b0);
        idle(1'b0, 30'h9);
        check_val("snp_hit",  64'(last_rhit),    64'd1);
        check_val("snp_be",   64'(last_rbyteen), 64'hC);
        idle(1'b0, 30'hA);
        check_val("snp_miss", 64'(last_rhit),    64'd0);
        check_val("snp_zero", 64'(last_rdata),   64'd0);
        idle(1'b1, '0);
        idle(1'b1, '0);

        // Full with simultaneous pop: push refused, then pointers wrap.
        for (int k = 0; k < 4; k++) wr(ADRW'(32 + k), DW'(32'hC000 + k), 4'hF, 1'b0);
        wr(30'h40, 32'hC0DE, 4'hF, 1'b1);
        check_val("fullpop_done", 64'(last_done), 64'd0);
        #2;
        check_val("fullpop_cnt", 64'(dut.count), 64'd3);
        for (int k = 0; k < 8; k++) wr(ADRW'(48 + k), DW'($urandom), 4'hF, 1'b1);
        #2;
        check_val("wrap_cnt", 64'(dut.count), 64'd3);
        for (int k = 0; k < 3; k++) idle(1'b1, '0);

        // Reset discards in-flight entries.
        for (int k = 0; k < 3; k++) wr(ADRW'(64 + k), DW'(k), 4'hF, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 30'h40);
        #2;
        check_val("rst2_empty", 64'(empty), 64'd1);
        check_val("rst2_memen", 64'(memen), 64'd0);
        check_val("rst2_rhit",  64'(rhit),  64'd0);
        wr(30'h50, 32'h5050, 4'hF, 1'b0);
        #2;
        check_val("rst2_adr", 64'(memadr), 64'h50);
        idle(1'b1, '0);

        // Random traffic over a small address range.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                 ADRW'($urandom_range(0, 5)), DW'($urandom), BW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ADRW'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
